ac_bmc_aux_seq: RTL and testbench

- S5/AUX power sequencer for the BMC rails P2V5_BMC_AUX, P1V2_BMC_AUX and P1V8_BMC_AUX.
- Sits directly upstream of the PCH sequencer. It supplies that block's P1V8 BMC power-good (oPWRGD_P1V8_BMC_AUX), its PCH enable (oPCH_PWR_EN) and the BMC SRST# it qualifies RSMRST# against (oRST_SRST_BMC_N).
- Independent of the master sequencer. It runs on a 2 MHz clock (500 ns/tick). It detects power-good timeouts and power-good drops, and latches a rail fault code.

---
 rtl/ac_pwrseq_pkg.sv | 32 +++
 rtl/ac_seq_timer.sv | 23 ++
 rtl/ac_bmc_aux_seq.sv | 159 +++++++++++++++
 tb/tb_ac_bmc_aux_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ac_pwrseq_pkg.sv
// ac_pwrseq_pkg: shared state encodings, 2 MHz tick constants and fault-code bit positions
package ac_pwrseq_pkg;

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_P2V5_ON  = 3'd1,
        ST_P1V2_ON  = 3'd2,
        ST_P1V8_ON  = 3'd3,
        ST_BMC_OK   = 3'd4,
        ST_P1V8_OFF = 3'd5,
        ST_P1V2_OFF = 3'd6,
        ST_P2V5_OFF = 3'd7
    } seq_state_t;

    localparam int CNT_W = 17;

    localparam logic [CNT_W-1:0] T_10uS_2M = 17'd20;
    localparam logic [CNT_W-1:0] T_4mS_2M  = 17'd8000;
    localparam logic [CNT_W-1:0] T_20mS_2M = 17'd40000;

    localparam int FLT_P2V5 = 0;
    localparam int FLT_P1V2 = 1;
    localparam int FLT_P1V8 = 2;

    function automatic logic [2:0] on_rail(seq_state_t s);
        on_rail = '0;
        on_rail[FLT_P2V5] = (s == ST_P2V5_ON);
        on_rail[FLT_P1V2] = (s == ST_P1V2_ON);
        on_rail[FLT_P1V8] = (s == ST_P1V8_ON);
    endfunction

endpackage

// File: rtl/ac_seq_timer.sv
// ac_seq_timer: load/enable up-counter that saturates at a limit and flags reaching it
module ac_seq_timer
    import ac_pwrseq_pkg::*;
(
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iLoad,
    input  logic             iEn,
    input  logic [CNT_W-1:0] iLimit,
    output logic             oDone
);

    logic [CNT_W-1:0] cnt;

    assign oDone = cnt >= iLimit;

    // Clear on load, otherwise count up and hold once the limit is reached
    always_ff @(posedge iClk or negedge iRst_n)
        if (!iRst_n) cnt <= '0;
        else if (iLoad) cnt <= '0;
        else if (iEn && !oDone) cnt <= cnt + 1'b1;

endmodule

// File: rtl/ac_bmc_aux_seq.sv
// ac_bmc_aux_seq: S5/AUX sequencer for the BMC P2V5/P1V2/P1V8 rails with timeout and drop fault latch
module ac_bmc_aux_seq
    import ac_pwrseq_pkg::*;
(
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iBMC_PWR_EN,
    input  logic       iPWRGD_P2V5_BMC_AUX,
    input  logic       iPWRGD_P1V2_BMC_AUX,
    input  logic       iPWRGD_P1V8_BMC_AUX,
    input  logic       iFLT_CLR,
    output logic       oFM_P2V5_BMC_EN,
    output logic       oFM_P1V2_BMC_EN,
    output logic       oFM_P1V8_BMC_EN,
    output logic       oPWRGD_P1V8_BMC_AUX,
    output logic       oBMC_PWRGD,
    output logic       oRST_SRST_BMC_N,
    output logic       oPCH_PWR_EN,
    output logic       oBMC_PWR_FLT,
    output logic [2:0] oBMC_FLT_CODE
);

    seq_state_t       state, prev_state;
    logic [2:0]       pg_meta, spg, spg_d;
    logic [2:0]       rail, en_vec, drop, to_code;
    logic [CNT_W-1:0] stage_limit;
    logic             stage_hit, stage_done, pg_rail, pg_off, srst_done, abort;

    assign rail       = on_rail(state);
    assign pg_rail    = |(rail & spg);
    assign pg_off     = state == ST_P1V8_OFF ? spg[FLT_P1V8] :
                        state == ST_P1V2_OFF ? spg[FLT_P1V2] : spg[FLT_P2V5];
    assign stage_done = (state == prev_state) && stage_hit;
    assign en_vec     = {oFM_P1V8_BMC_EN, oFM_P1V2_BMC_EN, oFM_P2V5_BMC_EN};
    assign drop       = en_vec & spg_d & ~spg;
    assign to_code    = (stage_done && !pg_rail) ? rail : 3'b000;
    assign abort      = (oBMC_PWR_FLT || !iBMC_PWR_EN) &&
                        (state inside {ST_P2V5_ON, ST_P1V2_ON, ST_P1V8_ON, ST_BMC_OK});

    // While an ON rail is still waiting for PWRGD the stage timer runs on to the timeout;
    // otherwise it only needs to reach the minimum stage time
    always_comb stage_limit = (|rail && !pg_rail) ? T_4mS_2M : T_10uS_2M;

    ac_seq_timer u_stage_tmr (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iLoad  (state != prev_state),
        .iEn    (1'b1),
        .iLimit (stage_limit),
        .oDone  (stage_hit)
    );

    // SRST# is a registered output, so the flag fires one count early to release on the 40000th edge
    ac_seq_timer u_srst_tmr (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iLoad  (state != ST_BMC_OK),
        .iEn    (state == ST_BMC_OK),
        .iLimit (T_20mS_2M - 1'b1),
        .oDone  (srst_done)
    );

    // Two-flop PWRGD synchronizers, one-cycle history for drop detection, registered P1V8 good
    always_ff @(posedge iClk or negedge iRst_n)
        if (!iRst_n) begin
            pg_meta             <= '0;
            spg                 <= '0;
            spg_d               <= '0;
            oPWRGD_P1V8_BMC_AUX <= 1'b0;
        end else begin
            pg_meta             <= {iPWRGD_P1V8_BMC_AUX, iPWRGD_P1V2_BMC_AUX, iPWRGD_P2V5_BMC_AUX};
            spg                 <= pg_meta;
            spg_d               <= spg;
            oPWRGD_P1V8_BMC_AUX <= spg[FLT_P1V8] && oFM_P1V8_BMC_EN;
        end

    // Fault latch: accumulates drop and timeout sources, cleared only from INIT
    always_ff @(posedge iClk or negedge iRst_n)
        if (!iRst_n) begin
            oBMC_PWR_FLT  <= 1'b0;
            oBMC_FLT_CODE <= '0;
        end else if (iFLT_CLR && state == ST_INIT) begin
            oBMC_PWR_FLT  <= 1'b0;
            oBMC_FLT_CODE <= '0;
        end else if (|(drop | to_code)) begin
            oBMC_PWR_FLT  <= 1'b1;
            oBMC_FLT_CODE <= oBMC_FLT_CODE | drop | to_code;
        end

    // Sequencer: rails up in order, orderly shutdown on fault or request removal
    always_ff @(posedge iClk or negedge iRst_n)
        if (!iRst_n) begin
            state           <= ST_INIT;
            prev_state      <= ST_INIT;
            oFM_P2V5_BMC_EN <= 1'b0;
            oFM_P1V2_BMC_EN <= 1'b0;
            oFM_P1V8_BMC_EN <= 1'b0;
            oBMC_PWRGD      <= 1'b0;
            oPCH_PWR_EN     <= 1'b0;
            oRST_SRST_BMC_N <= 1'b0;
        end else begin
            prev_state <= state;
            if (abort) begin
                state           <= ST_P1V8_OFF;
                oFM_P1V8_BMC_EN <= 1'b0;
                oBMC_PWRGD      <= 1'b0;
                oPCH_PWR_EN     <= 1'b0;
                oRST_SRST_BMC_N <= 1'b0;
            end else begin
                case (state)
                    ST_INIT:
                        if (iBMC_PWR_EN && !oBMC_PWR_FLT) begin
                            state           <= ST_P2V5_ON;
                            oFM_P2V5_BMC_EN <= 1'b1;
                        end
                    ST_P2V5_ON:
                        if (spg[FLT_P2V5] && stage_done) begin
                            state           <= ST_P1V2_ON;
                            oFM_P1V2_BMC_EN <= 1'b1;
                        end
                    ST_P1V2_ON:
                        if (spg[FLT_P1V2] && stage_done) begin
                            state           <= ST_P1V8_ON;
                            oFM_P1V8_BMC_EN <= 1'b1;
                        end
                    ST_P1V8_ON:
                        if (spg[FLT_P1V8] && stage_done) begin
                            state       <= ST_BMC_OK;
                            oBMC_PWRGD  <= 1'b1;
                            oPCH_PWR_EN <= 1'b1;
                        end
                    ST_BMC_OK:
                        if (srst_done) oRST_SRST_BMC_N <= 1'b1;
                    ST_P1V8_OFF:
                        if (!pg_off && stage_done) begin
                            state           <= ST_P1V2_OFF;
                            oFM_P1V2_BMC_EN <= 1'b0;
                        end
                    ST_P1V2_OFF:
                        if (!pg_off && stage_done) begin
                            state           <= ST_P2V5_OFF;
                            oFM_P2V5_BMC_EN <= 1'b0;
                        end
                    ST_P2V5_OFF:
                        if (!pg_off && stage_done) state <= ST_INIT;
                    default: begin
                        state           <= ST_INIT;
                        oFM_P2V5_BMC_EN <= 1'b0;
                        oFM_P1V2_BMC_EN <= 1'b0;
                        oFM_P1V8_BMC_EN <= 1'b0;
                        oBMC_PWRGD      <= 1'b0;
                        oPCH_PWR_EN     <= 1'b0;
                        oRST_SRST_BMC_N <= 1'b0;
                    end
                endcase
            end
        end

endmodule

// File: tb/tb_ac_bmc_aux_seq.sv
// tb_ac_bmc_aux_seq: directed bench for the BMC AUX sequencer with a simple VR model
module tb_ac_bmc_aux_seq;

    localparam int I_EN25 = 0;
    localparam int I_EN12 = 1;
    localparam int I_EN18 = 2;
    localparam int I_PG18 = 3;
    localparam int I_PWRGD = 4;
    localparam int I_PCH = 5;
    localparam int I_SRST = 6;
    localparam int I_FLT = 7;

    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iBMC_PWR_EN = 1'b0;
    logic       iFLT_CLR = 1'b0;
    logic [2:0] pg;
    logic [2:0] kill = '0;
    logic [2:0] keep = '0;
    logic       oFM_P2V5_BMC_EN, oFM_P1V2_BMC_EN, oFM_P1V8_BMC_EN;
    logic       oPWRGD_P1V8_BMC_AUX, oBMC_PWRGD, oRST_SRST_BMC_N, oPCH_PWR_EN, oBMC_PWR_FLT;
    logic [2:0] oBMC_FLT_CODE;
    logic [2:0] en;
    logic [10:0] outs;
    int         on_cnt [3];
    int         cyc = 0;
    int         t_hit = 0;
    int         t = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    ac_bmc_aux_seq dut (
        .iClk                (iClk),
        .iRst_n              (iRst_n),
        .iBMC_PWR_EN         (iBMC_PWR_EN),
        .iPWRGD_P2V5_BMC_AUX (pg[0]),
        .iPWRGD_P1V2_BMC_AUX (pg[1]),
        .iPWRGD_P1V8_BMC_AUX (pg[2]),
        .iFLT_CLR            (iFLT_CLR),
        .oFM_P2V5_BMC_EN     (oFM_P2V5_BMC_EN),
        .oFM_P1V2_BMC_EN     (oFM_P1V2_BMC_EN),
        .oFM_P1V8_BMC_EN     (oFM_P1V8_BMC_EN),
        .oPWRGD_P1V8_BMC_AUX (oPWRGD_P1V8_BMC_AUX),
        .oBMC_PWRGD          (oBMC_PWRGD),
        .oRST_SRST_BMC_N     (oRST_SRST_BMC_N),
        .oPCH_PWR_EN         (oPCH_PWR_EN),
        .oBMC_PWR_FLT        (oBMC_PWR_FLT),
        .oBMC_FLT_CODE       (oBMC_FLT_CODE)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    assign en   = {oFM_P1V8_BMC_EN, oFM_P1V2_BMC_EN, oFM_P2V5_BMC_EN};
    assign outs = {oBMC_FLT_CODE, oBMC_PWR_FLT, oRST_SRST_BMC_N, oPCH_PWR_EN, oBMC_PWRGD,
                   oPWRGD_P1V8_BMC_AUX, oFM_P1V8_BMC_EN, oFM_P1V2_BMC_EN, oFM_P2V5_BMC_EN};

    // VR model: PWRGD follows its enable after 5 ticks; kill holds it low, keep holds it high
    always @(negedge iClk)
        for (int i = 0; i < 3; i++) on_cnt[i] = en[i] ? on_cnt[i] + 1 : 0;

    always_comb
        for (int i = 0; i < 3; i++) pg[i] = keep[i] | (!kill[i] && en[i] && on_cnt[i] >= 5);

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_o(input int idx, input logic v, input int budget, input string tag);
        int n = 0;
        while (outs[idx] !== v && n < budget) begin
            @(negedge iClk);
            n++;
        end
        if (outs[idx] !== v) check({tag, "_timeout"}, int'(outs[idx]), int'(v));
        t_hit = cyc;
    endtask

    task automatic clear_fault();
        @(negedge iClk);
        iFLT_CLR = 1'b1;
        t = cyc;
        @(negedge iClk);
        iFLT_CLR = 1'b0;
        check("clr_flt", int'(outs[I_FLT]), 0);
        wait_o(I_EN25, 1'b1, 10, "restart_en25");
        check("restart_lat", t_hit - t, 2);
    endtask

    initial begin
        repeat (3) @(negedge iClk);
        check("reset_outs", int'(outs), 0);
        iRst_n = 1'b1;
        @(negedge iClk);

        iBMC_PWR_EN = 1'b1;
        wait_o(I_EN25, 1'b1, 10, "up_en25");
        t = t_hit;
        wait_o(I_EN12, 1'b1, 100, "up_en12");
        check("p1v2_en_gap", t_hit - t, 22);
        t = t_hit;
        wait_o(I_EN18, 1'b1, 100, "up_en18");
        check("p1v8_en_gap", t_hit - t, 22);
        t = t_hit;
        wait_o(I_PCH, 1'b1, 100, "up_pch");
        check("pch_gap", t_hit - t, 22);
        check("bmc_pwrgd", int'(outs[I_PWRGD]), 1);
        check("p1v8_pg_out", int'(outs[I_PG18]), 1);
        check("srst_held", int'(outs[I_SRST]), 0);
        t = t_hit;
        wait_o(I_SRST, 1'b1, 40100, "up_srst");
        check("srst_gap", t_hit - t, 40000);

        @(negedge iClk);
        kill[0] = 1'b1;
        t = cyc;
        wait_o(I_FLT, 1'b1, 10, "drop_flt");
        check("drop_flt_lat", t_hit - t, 3);
        check("drop_code", int'(outs[10:8]), 1);
        wait_o(I_PCH, 1'b0, 10, "drop_pch");
        check("drop_pch_lat", t_hit - t, 4);
        check("drop_srst", int'(outs[I_SRST]), 0);
        check("drop_en18", int'(outs[I_EN18]), 0);
        t = t_hit;
        wait_o(I_EN12, 1'b0, 100, "drop_en12");
        check("down_en12_gap", t_hit - t, 22);
        t = t_hit;
        wait_o(I_EN25, 1'b0, 100, "drop_en25");
        check("down_en25_gap", t_hit - t, 22);
        repeat (60) @(negedge iClk);
        check("drop_blocks_restart", int'(outs[I_EN25]), 0);
        check("drop_code_held", int'(outs[10:8]), 1);

        kill = 3'b010;
        clear_fault();
        wait_o(I_EN12, 1'b1, 100, "to_en12");
        t = t_hit;
        wait_o(I_FLT, 1'b1, 9000, "to_flt");
        check("p1v2_timeout", t_hit - t, 8002);
        check("to_code", int'(outs[10:8]), 2);
        wait_o(I_EN25, 1'b0, 200, "to_down");
        repeat (60) @(negedge iClk);
        check("to_blocks_restart", int'(outs[I_EN25]), 0);

        kill = 3'b000;
        clear_fault();
        wait_o(I_EN18, 1'b1, 200, "rq_en18");
        keep[2] = 1'b1;
        repeat (5) @(negedge iClk);
        iBMC_PWR_EN = 1'b0;
        t = cyc;
        wait_o(I_EN18, 1'b0, 10, "rq_en18_off");
        check("req_drop_lat", t_hit - t, 1);
        check("req_drop_noflt", int'(outs[I_FLT]), 0);
        repeat (50) @(negedge iClk);
        check("off_waits_pg", int'(outs[I_EN12]), 1);
        check("p1v8_pg_out_off", int'(outs[I_PG18]), 0);
        keep[2] = 1'b0;
        t = cyc;
        wait_o(I_EN12, 1'b0, 10, "rq_en12_off");
        check("off_pg_lat", t_hit - t, 3);
        wait_o(I_EN25, 1'b0, 100, "rq_en25_off");

        iBMC_PWR_EN = 1'b1;
        wait_o(I_PCH, 1'b1, 300, "ar_pch");
        #2;
        iRst_n = 1'b0;
        #1;
        check("async_rst_outs", int'(outs), 0);
        @(negedge iClk);
        iRst_n = 1'b1;
        wait_o(I_EN25, 1'b1, 10, "ar_en25");
        wait_o(I_PCH, 1'b1, 200, "ar_pch2");
        check("reseq_noflt", int'(outs[I_FLT]), 0);

        @(negedge iClk);
        kill = 3'b110;
        t = cyc;
        wait_o(I_FLT, 1'b1, 10, "dual_flt");
        check("dual_drop_lat", t_hit - t, 3);
        check("dual_code", int'(outs[10:8]), 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
